// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and a lane-expansion helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Expand a 4-bit byte-lane enable into a 32-bit bit mask.
    function automatic logic [31:0] lanes_to_bits(input logic [3:0] lanes);
        logic [31:0] bits;
        bits = '0;
        for (int n = 0; n < 4; n++) begin
            bits[8*n +: 8] = {8{lanes[n]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/ahb_byte_lane_mask.sv
// Little-endian byte-lane enable from transfer size and low address bits.
module ahb_byte_lane_mask
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] lanes
);

    // Select the lanes touched by a byte, halfword or word access.
    always_comb begin
        lanes = '0;
        case (hsize)
            HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: lanes = 4'b1111;
            default:    lanes = '0;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a flip-flop word memory, with programmable
// wait states, a two-cycle ERROR response and read-after-write forwarding.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] REGION_BYTES = 32'(4 * DEPTH_WORDS);

    state_t state_q, state_d;
    logic [2:0] cnt_q;

    // Data-phase copy of the accepted address phase.
    logic             vld_p1;
    logic             write_p1;
    logic [IDX_W-1:0] idx_p1;
    logic [1:0]       addr_lo_p1;
    logic [2:0]       size_p1;
    logic [3:0]       lanes_p1;

    logic [31:0] mem [DEPTH_WORDS];

    logic             htrans_active;
    logic [31:0]      offset;
    logic [IDX_W-1:0] acc_idx;
    logic             in_range;
    logic             misaligned;
    logic             err_a;
    logic             accept;
    logic             ok_a;
    logic             wr_commit;
    logic             rd_load;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      lane_bits;
    logic [31:0]      rd_word;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are ignored.
    always_comb begin
        htrans_active = 1'b0;
        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: htrans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  htrans_active = 1'b0;
            default:                   htrans_active = 1'b0;
        endcase
    end

    assign offset     = HADDR - BASE_ADDR;
    assign acc_idx    = offset[IDX_W+1:2];
    assign in_range   = (HADDR >= BASE_ADDR) && (offset < REGION_BYTES);
    assign misaligned = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                        ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign err_a      = !in_range || (HSIZE > HSIZE_WORD) || misaligned;
    assign accept     = HSEL && HREADY && htrans_active;
    assign ok_a       = accept && !err_a;

    ahb_byte_lane_mask u_lane_mask (
        .hsize   (size_p1),
        .addr_lo (addr_lo_p1),
        .lanes   (lanes_p1)
    );

    // A pending transfer completes on the edge that ends an IDLE-state cycle.
    assign wr_commit = (state_q == ST_IDLE) && vld_p1 && write_p1;

    // Read data is captured on the edge that starts the completion cycle:
    // the acceptance edge with no wait states, else the last wait edge.
    assign rd_load = (WAIT_STATES == 0) ? (ok_a && !HWRITE)
                   : ((state_q == ST_WAIT) && (cnt_q == 3'd1) && vld_p1 && !write_p1);
    assign rd_idx  = (WAIT_STATES == 0) ? acc_idx : idx_p1;

    // Forward a write completing on the same edge into the read word.
    assign lane_bits = lanes_to_bits(lanes_p1);
    assign rd_word   = (wr_commit && (idx_p1 == rd_idx))
                     ? ((mem[rd_idx] & ~lane_bits) | (HWDATA & lane_bits))
                     : mem[rd_idx];

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: acceptance is possible only where HREADY is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept && err_a)                  state_d = ST_ERR1;
                else if (accept && (WAIT_STATES > 0)) state_d = ST_WAIT;
                else                                  state_d = ST_IDLE;
            end
            ST_WAIT: state_d = (cnt_q <= 3'd1) ? ST_IDLE : ST_WAIT;
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: stall in WAIT and ERR1, signal ERROR in both ERR states.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // Control: pending-transfer flag, wait counter and read data register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_p1 <= 1'b0;
            cnt_q  <= 3'd0;
            HRDATA <= 32'd0;
        end else begin
            if (accept)                   vld_p1 <= !err_a;
            else if (state_q == ST_IDLE)  vld_p1 <= 1'b0;

            if (ok_a && (WAIT_STATES > 0)) cnt_q <= 3'(WAIT_STATES);
            else if (state_q == ST_WAIT)   cnt_q <= cnt_q - 3'd1;

            if (rd_load) HRDATA <= rd_word;
        end
    end

    // Address-phase capture into the data-phase registers.
    always_ff @(posedge CLK) begin
        if (accept) begin
            write_p1   <= HWRITE;
            idx_p1     <= acc_idx;
            addr_lo_p1 <= HADDR[1:0];
            size_p1    <= HSIZE;
        end
    end

    // Byte-lane write into memory on the completion edge.
    always_ff @(posedge CLK) begin
        if (wr_commit) begin
            for (int n = 0; n < 4; n++) begin
                if (lanes_p1[n]) mem[idx_p1][8*n +: 8] <= HWDATA[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with one wait state,
// one with zero wait states, driven from a shared address/data bus.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        nrst;
    logic        sel0, sel1;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'd0;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata;
    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1, resp0, resp1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.BASE_ADDR(32'h2000_0000), .DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
        .CLK(clk), .nRST(nrst), .HSEL(sel1), .HREADY(rdy1), .HTRANS(htrans),
        .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
        .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1)
    );

    ahb_sram_slave #(.BASE_ADDR(32'h2000_0000), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .CLK(clk), .nRST(nrst), .HSEL(sel0), .HREADY(rdy0), .HTRANS(htrans),
        .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
        .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One non-pipelined transfer on instance `which`, checked against
    // expected wait count, response and (for reads) data.
    task automatic xfer(input int which, input string tag, input logic [31:0] addr,
                        input logic wr, input logic [2:0] size, input logic [31:0] wd,
                        input int exp_waits, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd);
        int   waits;
        logic done;
        logic first_resp, last_resp;
        logic [31:0] rd;
        logic c_rdy, c_resp;
        sel0 = (which == 0); sel1 = (which == 1);
        htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        @(posedge clk); #1;
        htrans = 2'b00; sel0 = 1'b0; sel1 = 1'b0; hwdata = wd;
        waits = 0; done = 1'b0; first_resp = 1'b0; last_resp = 1'b0; rd = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            c_rdy  = (which == 1) ? rdy1 : rdy0;
            c_resp = (which == 1) ? resp1 : resp0;
            if (c == 0) first_resp = c_resp;
            if (c_rdy) begin
                done = 1'b1;
                last_resp = c_resp;
                rd = (which == 1) ? rdata1 : rdata0;
            end else begin
                waits++;
            end
        end
        check_vec({tag, "_done"}, 32'(done), 32'd1);
        check_vec({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check_vec({tag, "_resp1st"}, 32'(first_resp), 32'(exp_err));
        check_vec({tag, "_resp"}, 32'(last_resp), 32'(exp_err));
        if (chk_rd) check_vec({tag, "_rdata"}, rd, exp_rd);
        @(posedge clk); #1;
    endtask

    // Hold a non-transfer bus pattern for two cycles on instance 1.
    task automatic quiet_cycles(input string tag, input logic sel, input logic [1:0] tr,
                                input logic [31:0] exp_rd);
        sel1 = sel; htrans = tr; haddr = 32'h2000_0004; hwrite = 1'b1;
        hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_vec({tag, "_rdy"}, 32'(rdy1), 32'd1);
            check_vec({tag, "_resp"}, 32'(resp1), 32'd0);
            check_vec({tag, "_rdata"}, rdata1, exp_rd);
            @(posedge clk); #1;
        end
        sel1 = 1'b0; htrans = 2'b00;
    endtask

    initial begin
        nrst = 1'b0; sel0 = 1'b0; sel1 = 1'b0; htrans = 2'b00;
        haddr = '0; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;

        // Reset state
        @(negedge clk);
        check_vec("rst1_rdy", 32'(rdy1), 32'd1);
        check_vec("rst1_resp", 32'(resp1), 32'd0);
        check_vec("rst1_rdata", rdata1, 32'd0);
        check_vec("rst0_rdy", 32'(rdy0), 32'd1);
        check_vec("rst0_rdata", rdata0, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // One wait state, word write then read
        xfer(1, "w_dead", 32'h2000_0004, 1'b1, 3'd2, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 32'h0);
        xfer(1, "r_dead", 32'h2000_0004, 1'b0, 3'd2, 32'h0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Byte and halfword lane merges
        xfer(1, "w_base", 32'h2000_0004, 1'b1, 3'd2, 32'h1122_3344, 1, 1'b0, 1'b0, 32'h0);
        xfer(1, "w_byte", 32'h2000_0006, 1'b1, 3'd0, 32'hFFAA_FFFF, 1, 1'b0, 1'b0, 32'h0);
        xfer(1, "r_byte", 32'h2000_0004, 1'b0, 3'd2, 32'h0, 1, 1'b0, 1'b1, 32'h11AA_3344);
        xfer(1, "w_half", 32'h2000_0004, 1'b1, 3'd1, 32'hFFFF_5566, 1, 1'b0, 1'b0, 32'h0);
        xfer(1, "r_half", 32'h2000_0004, 1'b0, 3'd2, 32'h0, 1, 1'b0, 1'b1, 32'h11AA_5566);

        // Error responses leave memory and HRDATA untouched
        xfer(1, "w_w0", 32'h2000_0000, 1'b1, 3'd2, 32'hA5A5_A5A5, 1, 1'b0, 1'b0, 32'h0);
        xfer(1, "e_range", 32'h2000_0400, 1'b1, 3'd2, 32'hCAFE_F00D, 1, 1'b1, 1'b1, 32'h11AA_5566);
        xfer(1, "e_below", 32'h1FFF_FFFC, 1'b1, 3'd2, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 32'h0);
        xfer(1, "e_walign", 32'h2000_0002, 1'b1, 3'd2, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 32'h0);
        xfer(1, "e_halign", 32'h2000_0001, 1'b1, 3'd1, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 32'h0);
        xfer(1, "e_size", 32'h2000_0000, 1'b0, 3'd3, 32'h0, 1, 1'b1, 1'b1, 32'h11AA_5566);
        xfer(1, "r_w0", 32'h2000_0000, 1'b0, 3'd2, 32'h0, 1, 1'b0, 1'b1, 32'hA5A5_A5A5);
        xfer(1, "r_w1", 32'h2000_0004, 1'b0, 3'd2, 32'h0, 1, 1'b0, 1'b1, 32'h11AA_5566);

        // IDLE, BUSY and deselected cycles are zero-wait OKAY with no access
        quiet_cycles("q_idle", 1'b1, 2'b00, 32'h11AA_5566);
        quiet_cycles("q_busy", 1'b1, 2'b01, 32'h11AA_5566);
        quiet_cycles("q_nosel", 1'b0, 2'b10, 32'h11AA_5566);
        xfer(1, "r_q", 32'h2000_0004, 1'b0, 3'd2, 32'h0, 1, 1'b0, 1'b1, 32'h11AA_5566);
        xfer(1, "r_w0b", 32'h2000_0000, 1'b0, 3'd2, 32'h0, 1, 1'b0, 1'b1, 32'hA5A5_A5A5);

        // Zero wait states: write immediately followed by read of the same word
        xfer(0, "z_pre", 32'h2000_0008, 1'b1, 3'd2, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0);
        sel0 = 1'b1; htrans = 2'b10; haddr = 32'h2000_0008; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'h0BAD_F00D; hwrite = 1'b0;
        @(negedge clk);
        check_vec("fwd_wr_rdy", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        htrans = 2'b00; sel0 = 1'b0; hwdata = 32'h0;
        @(negedge clk);
        check_vec("fwd_rd_rdy", 32'(rdy0), 32'd1);
        check_vec("fwd_rd_resp", 32'(resp0), 32'd0);
        check_vec("fwd_rd_data", rdata0, 32'h0BAD_F00D);
        @(posedge clk); #1;
        xfer(0, "z_rd", 32'h2000_0008, 1'b0, 3'd2, 32'h0, 0, 1'b0, 1'b1, 32'h0BAD_F00D);

        // Reset in the middle of a wait state
        sel1 = 1'b1; htrans = 2'b10; haddr = 32'h2000_0010; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'b00; sel1 = 1'b0; hwdata = 32'h7777_7777;
        @(negedge clk);
        check_vec("mrst_wait", 32'(rdy1), 32'd0);
        #1 nrst = 1'b0;
        #1;
        check_vec("mrst_rdy", 32'(rdy1), 32'd1);
        check_vec("mrst_resp", 32'(resp1), 32'd0);
        check_vec("mrst_rdata", rdata1, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(negedge clk);
        check_vec("mrst_after_rdy", 32'(rdy1), 32'd1);
        check_vec("mrst_after_resp", 32'(resp1), 32'd0);
        @(posedge clk); #1;
        xfer(1, "r_post", 32'h2000_0004, 1'b0, 3'd2, 32'h0, 1, 1'b0, 1'b1, 32'h11AA_5566);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
